// File: rtl/branch_resolve_queue_if.sv
// Fetch/resolve/update handshake bundle between fetch, execute and the gshare predictor.
// The slave modport is the queue's view of the bundle; the master modport is the environment's view.
interface branch_resolve_queue_if #(
  parameter int CNT_W = 16
) ();
  logic             pred_val;
  logic             pred_rdy;
  logic [31:0]      pred_pc;
  logic             pred_taken;
  logic             resolve_val;
  logic             resolve_rdy;
  logic             resolve_taken;
  logic             update_en;
  logic             update_val;
  logic [31:0]      update_pc;
  logic             mispredict;
  logic [CNT_W-1:0] branch_count;
  logic [CNT_W-1:0] mispredict_count;

  modport slave (
    input  pred_val, pred_pc, pred_taken, resolve_val, resolve_taken,
    output pred_rdy, resolve_rdy, update_en, update_val, update_pc,
           mispredict, branch_count, mispredict_count
  );

  modport master (
    output pred_val, pred_pc, pred_taken, resolve_val, resolve_taken,
    input  pred_rdy, resolve_rdy, update_en, update_val, update_pc,
           mispredict, branch_count, mispredict_count
  );
endinterface

// File: rtl/branch_resolve_queue.sv
// In-order queue of in-flight predicted branches; on resolution it pops the oldest entry,
// drives the predictor update port, flags mispredictions (squashing the queue) and counts accuracy.
module branch_resolve_queue #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  branch_resolve_queue_if.slave bus
);
  localparam int AW = $clog2(DEPTH);

  logic [AW-1:0]    r_head;
  logic [AW-1:0]    r_tail;
  logic [AW:0]      r_count;
  logic [31:0]      r_pc_mem [DEPTH];
  logic             r_tk_mem [DEPTH];

  logic             r_update_en;
  logic             r_update_val;
  logic [31:0]      r_update_pc;
  logic             r_mispredict;
  logic [CNT_W-1:0] r_branch_count;
  logic [CNT_W-1:0] r_mispredict_count;

  logic             w_pred_rdy;
  logic             w_resolve_rdy;
  logic             w_push;
  logic             w_pop;
  logic             w_mis;
  logic             w_head_taken;
  logic [31:0]      w_head_pc;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  // count never exceeds DEPTH (a power of two), so its MSB alone marks "full"
  assign w_pred_rdy    = ~r_count[AW];
  assign w_resolve_rdy = (r_count != '0);
  assign w_head_pc     = r_pc_mem[r_head];
  assign w_head_taken  = r_tk_mem[r_head];
  assign w_push        = bus.pred_val && w_pred_rdy;
  assign w_pop         = bus.resolve_val && w_resolve_rdy;
  assign w_mis         = w_pop && (bus.resolve_taken != w_head_taken);

  // Entry storage carries no reset; validity is tracked purely by head/tail/count.
  always_ff @(posedge clk) begin
    if (w_push && !w_mis) begin
      r_pc_mem[r_tail] <= bus.pred_pc;
      r_tk_mem[r_tail] <= bus.pred_taken;
    end
  end

  // Queue pointers: a mispredict squashes everything, including a same-cycle push.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (w_mis) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_tail <= r_tail + 1'b1;
      if (w_pop)  r_head <= r_head + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Registered predictor-update and statistics outputs, one cycle after the pop.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_update_en        <= 1'b0;
      r_update_val       <= 1'b0;
      r_update_pc        <= '0;
      r_mispredict       <= 1'b0;
      r_branch_count     <= '0;
      r_mispredict_count <= '0;
    end else begin
      r_update_en  <= w_pop;
      r_mispredict <= w_mis;
      if (w_pop) begin
        r_update_val   <= bus.resolve_taken;
        r_update_pc    <= w_head_pc;
        r_branch_count <= sat_inc(r_branch_count);
      end
      if (w_mis) r_mispredict_count <= sat_inc(r_mispredict_count);
    end
  end

  assign bus.pred_rdy         = w_pred_rdy;
  assign bus.resolve_rdy      = w_resolve_rdy;
  assign bus.update_en        = r_update_en;
  assign bus.update_val       = r_update_val;
  assign bus.update_pc        = r_update_pc;
  assign bus.mispredict       = r_mispredict;
  assign bus.branch_count     = r_branch_count;
  assign bus.mispredict_count = r_mispredict_count;
endmodule

// File: tb/tb_branch_resolve_queue.sv
// Directed bench for branch_resolve_queue: main DUT with CNT_W=16 plus a CNT_W=2 copy for saturation.
module tb_branch_resolve_queue;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  branch_resolve_queue_if #(.CNT_W(16)) bif ();
  branch_resolve_queue_if #(.CNT_W(2))  bif2 ();

  branch_resolve_queue #(.DEPTH(4), .CNT_W(16)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bif.slave)
  );
  branch_resolve_queue #(.DEPTH(4), .CNT_W(2)) dut2 (
    .clk(clk), .reset_n(reset_n), .bus(bif2.slave)
  );

  always #5 clk = ~clk;

  task automatic idle();
    bif.pred_val = 0; bif.pred_pc = '0; bif.pred_taken = 0;
    bif.resolve_val = 0; bif.resolve_taken = 0;
    bif2.pred_val = 0; bif2.pred_pc = '0; bif2.pred_taken = 0;
    bif2.resolve_val = 0; bif2.resolve_taken = 0;
  endtask

  // Inputs set before the call are sampled at the next rising edge; returns 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] pc, input logic tk);
    idle();
    bif.pred_val = 1; bif.pred_pc = pc; bif.pred_taken = tk;
    step();
  endtask

  task automatic test_reset();
    idle();
    reset_n = 0;
    #12;
    checks++; if (bif.pred_rdy !== 1'b1) begin errors++; $display("FAIL reset_pred_rdy: got %b want 1", bif.pred_rdy); end
    checks++; if (bif.resolve_rdy !== 1'b0) begin errors++; $display("FAIL reset_resolve_rdy: got %b want 0", bif.resolve_rdy); end
    checks++; if (bif.update_en !== 1'b0 || bif.mispredict !== 1'b0 || bif.update_val !== 1'b0) begin
      errors++; $display("FAIL reset_pulses: got en=%b mis=%b val=%b want 0 0 0", bif.update_en, bif.mispredict, bif.update_val); end
    checks++; if (bif.update_pc !== 32'h0) begin errors++; $display("FAIL reset_update_pc: got %h want 0", bif.update_pc); end
    checks++; if (bif.branch_count !== 16'd0 || bif.mispredict_count !== 16'd0) begin
      errors++; $display("FAIL reset_counters: got %0d/%0d want 0/0", bif.branch_count, bif.mispredict_count); end
    @(negedge clk);
    reset_n = 1;
    step();
  endtask

  task automatic test_single();
    push(32'h20C, 1'b0);
    checks++; if (bif.resolve_rdy !== 1'b1 || bif.update_en !== 1'b0) begin
      errors++; $display("FAIL single_after_push: got rdy=%b en=%b want 1 0", bif.resolve_rdy, bif.update_en); end
    idle(); bif.resolve_val = 1; bif.resolve_taken = 0;
    step();
    checks++; if (bif.update_en !== 1'b1) begin errors++; $display("FAIL single_update_en: got %b want 1", bif.update_en); end
    checks++; if (bif.update_val !== 1'b0) begin errors++; $display("FAIL single_update_val: got %b want 0", bif.update_val); end
    checks++; if (bif.update_pc !== 32'h20C) begin errors++; $display("FAIL single_update_pc: got %h want 0000020c", bif.update_pc); end
    checks++; if (bif.mispredict !== 1'b0) begin errors++; $display("FAIL single_mispredict: got %b want 0", bif.mispredict); end
    checks++; if (bif.branch_count !== 16'd1) begin errors++; $display("FAIL single_branch_count: got %0d want 1", bif.branch_count); end
    checks++; if (bif.resolve_rdy !== 1'b0) begin errors++; $display("FAIL single_resolve_rdy: got %b want 0", bif.resolve_rdy); end
    idle();
    step();
    checks++; if (bif.update_en !== 1'b0 || bif.update_pc !== 32'h20C) begin
      errors++; $display("FAIL single_hold: got en=%b pc=%h want 0 0000020c", bif.update_en, bif.update_pc); end
  endtask

  task automatic test_fill();
    for (int i = 0; i < 4; i++) push(32'h100 + 32'(4 * i), 1'b1);
    checks++; if (bif.pred_rdy !== 1'b0) begin errors++; $display("FAIL fill_pred_rdy: got %b want 0", bif.pred_rdy); end
    push(32'h999, 1'b0);
    checks++; if (bif.pred_rdy !== 1'b0) begin errors++; $display("FAIL fill_ignored_push: got pred_rdy=%b want 0", bif.pred_rdy); end
    for (int i = 0; i < 4; i++) begin
      idle(); bif.resolve_val = 1; bif.resolve_taken = 1;
      step();
      checks++; if (bif.update_en !== 1'b1 || bif.update_pc !== 32'h100 + 32'(4 * i) || bif.update_val !== 1'b1) begin
        errors++; $display("FAIL fill_pop%0d: got en=%b pc=%h val=%b want 1 %h 1", i, bif.update_en, bif.update_pc, bif.update_val, 32'h100 + 32'(4 * i)); end
      checks++; if (bif.mispredict !== 1'b0) begin errors++; $display("FAIL fill_mis%0d: got %b want 0", i, bif.mispredict); end
    end
    checks++; if (bif.resolve_rdy !== 1'b0 || bif.pred_rdy !== 1'b1) begin
      errors++; $display("FAIL fill_empty: got resolve_rdy=%b pred_rdy=%b want 0 1", bif.resolve_rdy, bif.pred_rdy); end
    checks++; if (bif.branch_count !== 16'd5) begin errors++; $display("FAIL fill_branch_count: got %0d want 5", bif.branch_count); end
    idle();
    step();
  endtask

  task automatic test_squash();
    for (int i = 0; i < 3; i++) push(32'h300 + 32'(4 * i), 1'b1);
    idle();
    bif.resolve_val = 1; bif.resolve_taken = 0;
    bif.pred_val = 1; bif.pred_pc = 32'h200; bif.pred_taken = 1;
    step();
    checks++; if (bif.mispredict !== 1'b1 || bif.update_en !== 1'b1) begin
      errors++; $display("FAIL squash_pulse: got mis=%b en=%b want 1 1", bif.mispredict, bif.update_en); end
    checks++; if (bif.update_pc !== 32'h300 || bif.update_val !== 1'b0) begin
      errors++; $display("FAIL squash_update: got pc=%h val=%b want 00000300 0", bif.update_pc, bif.update_val); end
    checks++; if (bif.mispredict_count !== 16'd1 || bif.branch_count !== 16'd6) begin
      errors++; $display("FAIL squash_counts: got mis=%0d br=%0d want 1 6", bif.mispredict_count, bif.branch_count); end
    checks++; if (bif.resolve_rdy !== 1'b0 || bif.pred_rdy !== 1'b1) begin
      errors++; $display("FAIL squash_cleared: got resolve_rdy=%b pred_rdy=%b want 0 1", bif.resolve_rdy, bif.pred_rdy); end
    idle();
    step();
    checks++; if (bif.mispredict !== 1'b0 || bif.update_en !== 1'b0) begin
      errors++; $display("FAIL squash_pulse_end: got mis=%b en=%b want 0 0", bif.mispredict, bif.update_en); end
  endtask

  // Overlapped push/pop keeps one entry in flight while pointers walk through every slot.
  task automatic test_wrap();
    push(32'h400, 1'b0);
    for (int i = 1; i <= 10; i++) begin
      idle();
      bif.resolve_val = 1; bif.resolve_taken = 1'((i - 1) % 2);
      if (i < 10) begin
        bif.pred_val = 1; bif.pred_pc = 32'h400 + 32'(4 * i); bif.pred_taken = 1'(i % 2);
      end
      step();
      checks++; if (bif.update_en !== 1'b1 || bif.update_pc !== 32'h400 + 32'(4 * (i - 1)) || bif.update_val !== 1'((i - 1) % 2)) begin
        errors++; $display("FAIL wrap_pop%0d: got en=%b pc=%h val=%b want 1 %h %0d", i, bif.update_en, bif.update_pc, bif.update_val, 32'h400 + 32'(4 * (i - 1)), (i - 1) % 2); end
      checks++; if (bif.mispredict !== 1'b0 || bif.resolve_rdy !== (i < 10)) begin
        errors++; $display("FAIL wrap_state%0d: got mis=%b resolve_rdy=%b want 0 %0d", i, bif.mispredict, bif.resolve_rdy, i < 10); end
    end
    checks++; if (bif.branch_count !== 16'd16 || bif.mispredict_count !== 16'd1) begin
      errors++; $display("FAIL wrap_counts: got br=%0d mis=%0d want 16 1", bif.branch_count, bif.mispredict_count); end
    idle();
    step();
  endtask

  // While full, a same-cycle push is refused even though a pop frees a slot.
  task automatic test_full_simul();
    for (int i = 0; i < 4; i++) push(32'h500 + 32'(4 * i), 1'b1);
    idle();
    bif.resolve_val = 1; bif.resolve_taken = 1;
    bif.pred_val = 1; bif.pred_pc = 32'h600; bif.pred_taken = 1;
    step();
    checks++; if (bif.update_pc !== 32'h500 || bif.pred_rdy !== 1'b1) begin
      errors++; $display("FAIL full_simul_pop: got pc=%h pred_rdy=%b want 00000500 1", bif.update_pc, bif.pred_rdy); end
    for (int i = 1; i < 4; i++) begin
      idle(); bif.resolve_val = 1; bif.resolve_taken = 1;
      step();
      checks++; if (bif.update_pc !== 32'h500 + 32'(4 * i)) begin
        errors++; $display("FAIL full_simul_pc%0d: got %h want %h", i, bif.update_pc, 32'h500 + 32'(4 * i)); end
    end
    checks++; if (bif.resolve_rdy !== 1'b0 || bif.branch_count !== 16'd20) begin
      errors++; $display("FAIL full_simul_end: got resolve_rdy=%b br=%0d want 0 20", bif.resolve_rdy, bif.branch_count); end
    idle();
    step();
  endtask

  task automatic test_async_reset();
    push(32'h800, 1'b1);
    push(32'h804, 1'b1);
    idle(); bif.resolve_val = 1; bif.resolve_taken = 1;
    step();
    checks++; if (bif.update_en !== 1'b1 || bif.resolve_rdy !== 1'b1) begin
      errors++; $display("FAIL areset_pre: got en=%b resolve_rdy=%b want 1 1", bif.update_en, bif.resolve_rdy); end
    idle();
    reset_n = 0;
    #1;
    checks++; if (bif.update_en !== 1'b0 || bif.resolve_rdy !== 1'b0 || bif.pred_rdy !== 1'b1) begin
      errors++; $display("FAIL areset_immediate: got en=%b resolve_rdy=%b pred_rdy=%b want 0 0 1", bif.update_en, bif.resolve_rdy, bif.pred_rdy); end
    checks++; if (bif.branch_count !== 16'd0 || bif.mispredict_count !== 16'd0 || bif.update_pc !== 32'h0) begin
      errors++; $display("FAIL areset_counters: got br=%0d mis=%0d pc=%h want 0 0 0", bif.branch_count, bif.mispredict_count, bif.update_pc); end
    #1;
    reset_n = 1;
    bif.resolve_val = 1; bif.resolve_taken = 1;
    step();
    checks++; if (bif.update_en !== 1'b0 || bif.branch_count !== 16'd0) begin
      errors++; $display("FAIL areset_empty_resolve: got en=%b br=%0d want 0 0", bif.update_en, bif.branch_count); end
    idle();
    step();
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 5; i++) begin
      idle(); bif2.pred_val = 1; bif2.pred_pc = 32'h700 + 32'(4 * i); bif2.pred_taken = 1;
      step();
      idle(); bif2.resolve_val = 1; bif2.resolve_taken = 0;
      step();
      checks++; if (bif2.mispredict !== 1'b1) begin errors++; $display("FAIL sat_mis%0d: got %b want 1", i, bif2.mispredict); end
      checks++; if (bif2.branch_count !== 2'((i < 3) ? i + 1 : 3) || bif2.mispredict_count !== 2'((i < 3) ? i + 1 : 3)) begin
        errors++; $display("FAIL sat_count%0d: got br=%0d mis=%0d want %0d", i, bif2.branch_count, bif2.mispredict_count, (i < 3) ? i + 1 : 3); end
    end
    idle();
    step();
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_single();
    test_fill();
    test_squash();
    test_wrap();
    test_full_simul();
    test_async_reset();
    test_saturation();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/branch_resolve_queue.md
Name: branch_resolve_queue

Overview:
- Resolution-side companion to the gshare predictor.
- Records every prediction issued at fetch (PC plus predicted direction) in an in-order queue of in-flight branches.
- When branches resolve in execute, pops the oldest entry and drives the predictor's update interface (update_en, update_val, update PC).
- Flags mispredictions, squashes wrong-path entries and keeps accuracy counters.

Parameters:
DEPTH, 4, number of in-flight branch entries; power of two, >= 2
CNT_W, 16, width of the branch and mispredict statistics counters

Ports:
clk  input  1  clock; all state updates on rising edge
reset_n  input  1  asynchronous, active-low reset
pred_val  input  1  fetch is issuing a predicted branch this cycle
pred_rdy  output  1  queue can accept an entry (count < DEPTH)
pred_pc  input  32  PC of the predicted branch
pred_taken  input  1  direction produced by the predictor for pred_pc
resolve_val  input  1  oldest in-flight branch resolved this cycle
resolve_rdy  output  1  queue holds at least one entry (count > 0)
resolve_taken  input  1  actual branch outcome
update_en  output  1  one-cycle pulse driving the predictor update enable
update_val  output  1  actual outcome sent to the predictor
update_pc  output  32  PC of the branch being updated; muxed onto predictor PC while update_en=1
mispredict  output  1  one-cycle pulse, resolved outcome != stored prediction
branch_count  output  CNT_W  number of resolved branches, saturating
mispredict_count  output  CNT_W  number of mispredicted branches, saturating

Behaviour:
- Reset (reset_n=0, takes effect immediately):
  - head=tail=count=0.
  - update_en, update_val, update_pc, mispredict, branch_count and mispredict_count all 0.
  - Consequently pred_rdy=1 and resolve_rdy=0.
  - Reset mid-operation discards all entries with no update pulse.
- Storage:
  - Circular buffer of DEPTH entries {pc[31:0], taken}.
  - head and tail are log2(DEPTH) bits and wrap modulo DEPTH.
  - count is log2(DEPTH)+1 bits.
- Push fires when pred_val && pred_rdy:
  - Entry written at tail, then tail+1 and count+1.
  - pred_val while full is ignored (no write, no state change).
- Pop fires when resolve_val && resolve_rdy:
  - Compare resolve_taken against the head entry's stored taken.
  - resolve_val while empty is ignored entirely: no pulses, counters unchanged.
- Outputs are registered with 1-cycle latency. On the edge ending a pop cycle:
  - update_en=1, update_val=resolve_taken, update_pc=head.pc.
  - mispredict=(resolve_taken != head.taken).
  - Next cycle update_en and mispredict return to 0 unless another pop fires.
  - update_val and update_pc hold their last values.
- Correct prediction on pop: head+1, count-1.
- Misprediction on pop (squash):
  - All entries are wrong-path and are cleared: head=tail=0, count=0.
  - A push firing in the same cycle is also discarded.
  - pred_rdy=1 and resolve_rdy=0 the following cycle.
- Simultaneous push and pop, correctly predicted:
  - Both occur and count is unchanged.
  - The full condition is evaluated before the pop, so there is no same-cycle bypass while full.
  - Pop of the only entry while pushing leaves count=1 with the new entry at head.
- Counters, on each pop:
  - branch_count+1.
  - If mispredicted, mispredict_count+1.
  - Each counter saturates at 2^CNT_W-1 and never wraps.
- Back-to-back pops on consecutive cycles produce consecutive update_en pulses, each carrying its own PC and outcome.
- Combinational readies: pred_rdy=(count<DEPTH), resolve_rdy=(count!=0).

Test Plan:
- Reset, then push pc=0x20C pred_taken=0; next cycle resolve taken=0 -> one cycle later update_en=1, update_val=0, update_pc=0x20C, mispredict=0, branch_count=1, resolve_rdy=0.
- Push 4 entries, pc=0x100/0x104/0x108/0x10C, all pred_taken=1 -> pred_rdy=0. A 5th push is ignored. Resolve 4x taken=1 on consecutive cycles -> four consecutive update_en pulses with update_pc in order 0x100..0x10C, mispredict never 1, count returns to 0.
- Push 3 entries; resolve oldest with taken=0 against pred_taken=1 while also pushing pc=0x200 -> mispredict=1, mispredict_count=1, update_pc=oldest PC. Next cycle resolve_rdy=0 and pred_rdy=1; the 0x200 entry is absent.
- Wrap-around: run 10 push/resolve pairs through DEPTH=4 with alternating outcomes that match their predictions -> update_pc follows push order, no mispredicts, count never exceeds 4.
- Fill 2 entries, assert reset_n=0 for a partial cycle -> immediately count=0, update_en=0, counters=0. After release, resolve_val=1 produces no update_en.
- With CNT_W=2, resolve 5 mispredicted single-entry branches -> branch_count and mispredict_count stick at 3.
